// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: qualifies DREQ/software requests and picks a channel by fixed or rotating priority.
// It also runs the HRQ/HLDA handshake and drives DACK and the active-channel index.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_dreq,
  input  logic [7:0]        i_command_reg,
  input  logic [NUM_CH-1:0] i_mask_reg,
  input  logic [NUM_CH-1:0] i_request_reg,
  input  logic              i_hlda,
  input  logic              i_xfer_done,
  output logic              o_hrq,
  output logic [NUM_CH-1:0] o_dack,
  output logic [CH_W-1:0]   o_active_ch,
  output logic              o_ch_valid,
  output logic [NUM_CH-1:0] o_req_clr,
  output logic              o_abort_pulse
);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE, RELEASE} state_t;
  state_t            r_state, w_next;
  logic [NUM_CH-1:0] w_dreq_s, w_pending, w_sel, w_grant, r_req_clr;
  logic [CH_W-1:0]   r_active_ch, r_prio_ptr, w_base, w_win;
  logic              r_abort, w_done, w_abort, w_unused;
  assign w_unused  = ^{i_command_reg[5], i_command_reg[3], i_command_reg[1:0]};
  assign w_dreq_s  = i_command_reg[6] ? ~i_dreq : i_dreq;
  assign w_pending = (w_dreq_s & ~i_mask_reg) | i_request_reg;
  assign w_base    = i_command_reg[4] ? r_prio_ptr : '0;
  // Scan from lowest priority upward so the first pending channel after w_base wins.
  always_comb begin
    w_win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_pending[(int'(w_base) + i) % NUM_CH]) w_win = CH_W'((int'(w_base) + i) % NUM_CH);
  end
  assign w_done  = (r_state == ACTIVE) && i_xfer_done;
  assign w_abort = (r_state == ACTIVE) && !i_xfer_done && !i_hlda;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_pending && !i_command_reg[2]) w_next = REQ;
      REQ:     if (w_pending == '0 || i_command_reg[2]) w_next = IDLE;
               else if (i_hlda) w_next = ACTIVE;
      ACTIVE:  w_next = w_done ? RELEASE : (w_abort ? IDLE : ACTIVE);
      RELEASE: if (!i_hlda) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_active_ch <= '0;
      r_prio_ptr  <= '0;
      r_req_clr   <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == REQ && w_next == ACTIVE) r_active_ch <= w_win;
      // Only a software request bit that is actually set needs clearing.
      r_req_clr <= w_done ? (w_sel & i_request_reg) : '0;
      r_abort   <= w_abort;
      if (w_done && i_command_reg[4]) r_prio_ptr <= CH_W'((int'(r_active_ch) + 1) % NUM_CH);
    end
  end
  assign w_sel         = {{(NUM_CH-1){1'b0}}, 1'b1} << r_active_ch;
  assign w_grant       = (r_state == ACTIVE) ? w_sel : '0;
  assign o_dack        = i_command_reg[7] ? w_grant : ~w_grant;
  assign o_hrq         = (r_state == REQ) || (r_state == ACTIVE);
  assign o_ch_valid    = (r_state == ACTIVE);
  assign o_active_ch   = r_active_ch;
  assign o_req_clr     = r_req_clr;
  assign o_abort_pulse = r_abort;
endmodule
